// File: rtl/mem_access_arbiter.sv
// Memory access arbiter: four executers, instruction fetch and two hyper fetch
// requesters share one downstream port through an IDLE/GRANT/WAIT handshake.
module mem_access_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       main_clk,
  input  logic       reset,
  input  logic [3:0] req_exec,
  input  logic       req_ifetch,
  input  logic       req_hyper0,
  input  logic       req_hyper1,
  input  logic       void_hyper,
  input  logic       mem_ready,
  input  logic       mem_done,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [3:0] ack_exec,
  output logic       ack_ifetch,
  output logic       ack_hyper0,
  output logic       ack_hyper1,
  output logic       hyper_abort,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [2:0] ID_IFETCH = 3'd4;
  localparam logic [2:0] ID_HYPER0 = 3'd5;
  localparam logic [2:0] ID_HYPER1 = 3'd6;

  state_t     r_state;
  logic       r_grant_valid;
  logic [2:0] r_grant_id;
  logic [6:0] r_ack;
  logic       r_abort;
  logic       r_busy;
  logic [1:0] r_rr_ptr;
  logic [3:0] r_starve;

  state_t     w_state_nx;
  logic       w_gv_nx;
  logic [2:0] w_id_nx;
  logic [6:0] w_ack_nx;
  logic       w_abort_nx;
  logic [1:0] w_rr_nx;
  logic [3:0] w_starve_nx;
  logic       w_exec_found;
  logic [1:0] w_exec_idx;
  logic [2:0] w_winner;
  logic       w_any_req;
  logic       w_pulse;
  logic       w_void_hit;

  assign w_any_req  = (|req_exec) | req_ifetch | req_hyper0 | req_hyper1;
  // The cycle carrying an ack/abort pulse is a dead cycle for arbitration.
  assign w_pulse    = (|r_ack) | r_abort;
  assign w_void_hit = void_hyper &&
                      ((r_grant_id == ID_HYPER0) || (r_grant_id == ID_HYPER1));

  // Round-robin search from r_rr_ptr upward; descending loop lets the
  // closest requester to the pointer win.
  always_comb begin
    w_exec_found = 1'b0;
    w_exec_idx   = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_exec[2'(r_rr_ptr + 2'(i))]) begin
        w_exec_found = 1'b1;
        w_exec_idx   = 2'(r_rr_ptr + 2'(i));
      end
    end
  end

  always_comb begin
    w_winner = ID_HYPER1;
    if (req_ifetch && (r_starve == LIMIT)) begin
      w_winner = ID_IFETCH;
    end else if (w_exec_found) begin
      w_winner = {1'b0, w_exec_idx};
    end else if (req_ifetch) begin
      w_winner = ID_IFETCH;
    end else if (req_hyper0) begin
      w_winner = ID_HYPER0;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_gv_nx     = r_grant_valid;
    w_id_nx     = r_grant_id;
    w_ack_nx    = 7'd0;
    w_abort_nx  = 1'b0;
    w_rr_nx     = r_rr_ptr;
    w_starve_nx = r_starve;
    case (r_state)
      S_IDLE: begin
        if (w_any_req && !w_pulse) begin
          w_state_nx = S_GRANT;
          w_gv_nx    = 1'b1;
          w_id_nx    = w_winner;
          if (w_winner == ID_IFETCH) begin
            w_starve_nx = 4'd0;
          end else if (!w_winner[2]) begin
            w_rr_nx = w_exec_idx + 2'd1;
            if (req_ifetch && (r_starve < LIMIT)) begin
              w_starve_nx = r_starve + 4'd1;
            end
          end
        end
      end
      S_GRANT: begin
        if (w_void_hit) begin
          w_state_nx = S_IDLE;
          w_gv_nx    = 1'b0;
          w_abort_nx = 1'b1;
        end else if (mem_ready) begin
          w_state_nx = S_WAIT;
          w_gv_nx    = 1'b0;
        end
      end
      S_WAIT: begin
        // A void wins over a completion arriving in the same cycle.
        if (w_void_hit) begin
          w_state_nx = S_IDLE;
          w_abort_nx = 1'b1;
        end else if (mem_done) begin
          w_state_nx = S_IDLE;
          w_ack_nx   = 7'b000_0001 << r_grant_id;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gv_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= 3'd0;
      r_ack         <= 7'd0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_rr_ptr      <= 2'd0;
      r_starve      <= 4'd0;
    end else begin
      r_state       <= w_state_nx;
      r_grant_valid <= w_gv_nx;
      r_grant_id    <= w_id_nx;
      r_ack         <= w_ack_nx;
      r_abort       <= w_abort_nx;
      r_busy        <= (w_state_nx != S_IDLE);
      r_rr_ptr      <= w_rr_nx;
      r_starve      <= w_starve_nx;
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign ack_exec    = r_ack[3:0];
  assign ack_ifetch  = r_ack[4];
  assign ack_hyper0  = r_ack[5];
  assign ack_hyper1  = r_ack[6];
  assign hyper_abort = r_abort;
  assign busy        = r_busy;

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive executer grants tolerated while instruction fetch waits (range 1..15).
REQ-002 SHALL have port main_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_exec  input  4  per-executer request for a general or stack access, bit k = executer k.
REQ-005 SHALL have port req_ifetch  input  1  instruction fetch request.
REQ-006 SHALL have ports req_hyper0 / req_hyper1  input  1 each  hyper instruction fetch requests.
REQ-007 SHALL have port void_hyper  input  1  voids any in-progress hyper fetch grant.
REQ-008 SHALL have port mem_ready  input  1  downstream accepts the presented grant this cycle.
REQ-009 SHALL have port mem_done  input  1  downstream completed the accepted access this cycle.
REQ-010 SHALL have port grant_valid  output  1  a grant is being presented downstream.
REQ-011 SHALL have port grant_id  output  3  granted requester: 0-3 executer k, 4 ifetch, 5 hyper0, 6 hyper1.
REQ-012 SHALL have port ack_exec  output  4  one-cycle acknowledge pulse per executer.
REQ-013 SHALL have ports ack_ifetch / ack_hyper0 / ack_hyper1  output  1 each  one-cycle acknowledge pulses.
REQ-014 SHALL have port hyper_abort  output  1  one-cycle pulse when a hyper grant is voided.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, GRANT, WAIT; all outputs registered.
REQ-017 IDLE: if any request high, SHALL latch winner into grant_id, set grant_valid, enter GRANT next cycle; else stay IDLE.
REQ-018 Priority SHALL be: ifetch if starve counter = STARVE_LIMIT; else executers (round-robin); else ifetch; else hyper0; else hyper1.
REQ-019 Round-robin SHALL search executers starting at 2-bit rr_ptr upward with wrap 3->0; after granting executer k, rr_ptr = (k+1) mod 4.
REQ-020 Starve counter (4-bit, saturating at STARVE_LIMIT) SHALL increment on each executer grant while req_ifetch high, and clear to 0 on ifetch grant.
REQ-021 GRANT: grant_valid high, grant_id stable; on mem_ready high SHALL enter WAIT and drop grant_valid next cycle.
REQ-022 WAIT: on mem_done high SHALL pulse the matching ack for exactly the following cycle and return to IDLE in that same following cycle.
REQ-023 Arbitration SHALL not occur in the cycle an ack is pulsed; earliest next grant_valid is 1 cycle after the ack (back-to-back grant spacing: 4 cycles minimum with mem_ready/mem_done immediate).
REQ-024 mem_ready and mem_done asserted simultaneously in GRANT SHALL be treated as ready only; mem_done outside WAIT SHALL be ignored.
REQ-025 void_hyper high in GRANT or WAIT with grant_id 5 or 6 SHALL return to IDLE next cycle, pulse hyper_abort, issue no ack, precede mem_done if both high.
REQ-026 void_hyper high in IDLE SHALL NOT void a hyper grant selected in that same cycle; void_hyper with non-hyper grant SHALL have no effect.
REQ-027 Requests deasserting before ack are protocol errors; behaviour SHALL remain as latched (grant completes normally).
REQ-028 At most one ack/abort bit SHALL be high in any cycle.

Reset
REQ-029 reset high SHALL force state IDLE, grant_valid=0, grant_id=0, all acks=0, hyper_abort=0, busy=0, rr_ptr=0, starve counter=0 on next edge.
REQ-030 reset during GRANT or WAIT SHALL drop the access with no ack pulse; reset has priority over mem_ready, mem_done, void_hyper.

Verification
REQ-031 req_exec=4'b1111 held, mem_ready/mem_done immediate -> grant_id sequence 0,1,2,3,0; each ack_exec bit pulses once per grant.
REQ-032 req_exec=4'b0001 and req_ifetch held, STARVE_LIMIT=8 -> 8 grants to executer 0, 9th grant_id=4, ack_ifetch pulse, counter returns to 0.
REQ-033 req_hyper0, req_hyper1 only -> grant_id=5 first, then 6; hyper0 grant, void_hyper in WAIT -> hyper_abort pulse, no ack_hyper0, IDLE next cycle.
REQ-034 void_hyper and req_hyper1 both rise in IDLE -> grant_id=6 presented, completes with ack_hyper1.
REQ-035 reset pulsed in WAIT with executer 2 granted -> no ack_exec, busy=0, next grant from req_exec=4'b0100 starts with rr_ptr=0 search, grant_id=2.
REQ-036 mem_ready held low 20 cycles in GRANT -> grant_valid and grant_id stable all 20 cycles, no ack.
